// File: rtl/protected_reg_arbiter.sv
// protected_reg_arbiter
// Round-robin arbiter in front of a single access-controlled register.
// Each winning request is latched, its user ID is checked against AUTH_MASK,
// and only then may a write reach the register: IDLE -> CHECK -> RESP.
// Optional build macro PRA_LOCKOUT_EN adds per-slot consecutive-denial
// counters, sticky lock bits and the extra `locked` output.
module protected_reg_arbiter #(
  parameter int           NREQ      = 4,
  parameter int           DW        = 8,
  parameter int           UIDW      = 3,
  parameter logic [7:0]   AUTH_MASK = 8'h10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*UIDW-1:0] usr_id,
  input  logic [NREQ*DW-1:0]   data_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic                 err,
  output logic [DW-1:0]        data_out,
  output logic [7:0]           viol_cnt
`ifdef PRA_LOCKOUT_EN
  ,
  output logic [NREQ-1:0]      locked
`endif
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_r;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     win_r;
  logic [UIDW-1:0]   id_r;
  logic              we_r;
  logic [DW-1:0]     data_r;
  logic              auth_r;

  logic [NREQ-1:0]   req_eff_s;
  logic [PW-1:0]     win_s;
  logic              win_vld_s;

`ifdef PRA_LOCKOUT_EN
  logic [1:0]        deny_cnt_r [NREQ];
`endif

  // Write authorization: reads always pass; IDs beyond the 8-bit mask never write.
  function automatic logic auth_ok(input logic [UIDW-1:0] id, input logic wr);
    logic [31:0] idx;
    logic        ok;
    idx = 32'(id);
    if (!wr) begin
      ok = 1'b1;
    end else if (idx < 32'd8) begin
      ok = AUTH_MASK[idx[2:0]];
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

`ifdef PRA_LOCKOUT_EN
  assign req_eff_s = req & ~locked;
`else
  assign req_eff_s = req;
`endif

  // Round-robin pick: first eligible slot at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_s     = {PW{1'b0}};
    win_vld_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!win_vld_s && req_eff_s[idx]) begin
        win_vld_s = 1'b1;
        win_s     = PW'(idx);
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Main FSM: latch winner, check authorization, then commit or deny.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= {PW{1'b0}};
      win_r    <= {PW{1'b0}};
      id_r     <= {UIDW{1'b0}};
      we_r     <= 1'b0;
      data_r   <= {DW{1'b0}};
      auth_r   <= 1'b0;
      gnt      <= {NREQ{1'b0}};
      ack      <= 1'b0;
      err      <= 1'b0;
      data_out <= {DW{1'b0}};
      viol_cnt <= 8'd0;
`ifdef PRA_LOCKOUT_EN
      locked   <= {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
        deny_cnt_r[i] <= 2'd0;
      end
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (win_vld_s) begin
            win_r   <= win_s;
            id_r    <= usr_id[int'(win_s)*UIDW +: UIDW];
            we_r    <= we[win_s];
            data_r  <= data_in[int'(win_s)*DW +: DW];
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            state_r <= CHECK;
          end else begin
            state_r <= IDLE;
          end
        end
        CHECK: begin
          auth_r  <= auth_ok(id_r, we_r);
          state_r <= RESP;
        end
        RESP: begin
          if (auth_r) begin
            ack <= 1'b1;
            if (we_r) begin
              data_out <= data_r;
            end else begin
              data_out <= data_out;
            end
`ifdef PRA_LOCKOUT_EN
            deny_cnt_r[win_r] <= 2'd0;
`endif
          end else begin
            err <= 1'b1;
            if (viol_cnt != 8'hFF) begin
              viol_cnt <= viol_cnt + 8'd1;
            end else begin
              viol_cnt <= viol_cnt;
            end
`ifdef PRA_LOCKOUT_EN
            if (deny_cnt_r[win_r] == 2'd3) begin
              locked[win_r] <= 1'b1;
            end else begin
              deny_cnt_r[win_r] <= deny_cnt_r[win_r] + 2'd1;
            end
`endif
          end
          gnt <= {NREQ{1'b0}};
          if (win_r == PW'(NREQ - 1)) begin
            ptr_r <= {PW{1'b0}};
          end else begin
            ptr_r <= win_r + {{(PW-1){1'b0}}, 1'b1};
          end
          state_r <= IDLE;
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_protected_reg_arbiter.sv
// tb_protected_reg_arbiter
// Scoreboard bench: expected responses are queued when a request is driven
// and compared against every ack/err pulse. Build with PRA_LOCKOUT_EN to
// exercise the lockout variant.
module tb_protected_reg_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int UIDW = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ*UIDW-1:0] usr_id;
  logic [NREQ*DW-1:0]   data_in;
  logic [NREQ-1:0]      gnt;
  logic                 ack;
  logic                 err;
  logic [DW-1:0]        data_out;
  logic [7:0]           viol_cnt;
`ifdef PRA_LOCKOUT_EN
  logic [NREQ-1:0]      locked;
`endif

  protected_reg_arbiter #(
    .NREQ(NREQ), .DW(DW), .UIDW(UIDW), .AUTH_MASK(8'h10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .usr_id(usr_id),
    .data_in(data_in), .gnt(gnt), .ack(ack), .err(err),
    .data_out(data_out), .viol_cnt(viol_cnt)
`ifdef PRA_LOCKOUT_EN
    , .locked(locked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic       is_ack;
    logic [7:0] dout;
    logic [7:0] viol;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [7:0]      m_data   = 8'h00;
  logic [7:0]      m_viol   = 8'h00;
  logic [7:0]      m_mask   = 8'h10;
  logic [NREQ-1:0] last_gnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: authorization, register contents and saturating violations.
  task automatic push_exp(input int slot, input logic [2:0] id, input logic wr, input logic [7:0] d);
    exp_t e;
    logic ok;
    ok = !wr || m_mask[id];
    if (ok && wr) m_data = d;
    if (!ok && m_viol != 8'hFF) m_viol = m_viol + 8'd1;
    e.slot = slot; e.is_ack = ok; e.dout = m_data; e.viol = m_viol;
    exp_q.push_back(e);
  endtask

  task automatic set_slot(input int slot, input logic [2:0] id, input logic wr, input logic [7:0] d);
    usr_id[slot*UIDW +: UIDW] = id;
    we[slot]                  = wr;
    data_in[slot*DW +: DW]    = d;
  endtask

  task automatic wait_resp();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (ack || err) seen = 1'b1;
    end
    check_eq("resp_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_txn(input int slot, input logic [2:0] id, input logic wr, input logic [7:0] d);
    @(negedge clk);
    set_slot(slot, id, wr, d);
    req[slot] = 1'b1;
    push_exp(slot, id, wr, d);
    @(negedge clk);
    check_eq("gnt_latency", 32'(gnt), 32'(1 << slot));
    wait_resp();
    req[slot] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_data = 8'h00;
    m_viol = 8'h00;
  endtask

  // Monitor: one-hot grant, exclusive responses, and scoreboard compare.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (gnt != '0) last_gnt = gnt;
      if (ack || err) begin
        exp_t e;
        check_eq("ack_err_excl", 32'(ack && err), 32'd0);
        check_eq("resp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("resp_slot", 32'(last_gnt), 32'(1 << e.slot));
          check_eq("resp_ack", 32'(ack), 32'(e.is_ack));
          check_eq("resp_err", 32'(err), 32'(!e.is_ack));
          check_eq("data_out", 32'(data_out), 32'(e.dout));
          check_eq("viol_cnt", 32'(viol_cnt), 32'(e.viol));
        end
      end
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b0; req = '0; we = '0; usr_id = '0; data_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ack", 32'(ack | err), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_viol", 32'(viol_cnt), 32'd0);
    rst_n = 1'b1;

    // Authorized write, denied write, read with unauthorized id.
    do_txn(0, 3'd4, 1'b1, 8'hAB);
    do_txn(0, 3'd3, 1'b1, 8'hCD);
    do_txn(2, 3'd3, 1'b0, 8'hEE);
    do_txn(3, 3'd4, 1'b1, 8'h3C);
    do_txn(1, 3'd7, 1'b1, 8'h99);

    // Reset in CHECK aborts the write and clears the register at once.
    @(negedge clk);
    set_slot(0, 3'd4, 1'b1, 8'h55);
    req[0] = 1'b1;
    @(negedge clk);
    check_eq("mid_gnt_pre", 32'(gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", 32'(data_out), 32'd0);
    check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1; m_data = 8'h00; m_viol = 8'h00;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack || err) cnt++;
    end
    check_eq("mid_no_resp", 32'(cnt), 32'd0);

    // All four slots at once: served 0,1,2,3 from a fresh pointer.
    do_reset();
    @(negedge clk);
    for (int s = 0; s < NREQ; s++) begin
      set_slot(s, 3'd4, 1'b1, 8'(s + 1));
      push_exp(s, 3'd4, 1'b1, 8'(s + 1));
    end
    req = '1;
    for (int s = 0; s < NREQ; s++) begin
      wait_resp();
      req[s] = 1'b0;
    end
    check_eq("rr_final_data", 32'(data_out), 32'h04);

    // Repeated denials on slot 1.
    do_reset();
    for (int i = 0; i < 4; i++) do_txn(1, 3'd3, 1'b1, 8'(8'h10 + i));
`ifdef PRA_LOCKOUT_EN
    check_eq("locked", 32'(locked), 32'h2);
    @(negedge clk);
    set_slot(1, 3'd3, 1'b1, 8'h66);
    set_slot(0, 3'd4, 1'b1, 8'h77);
    push_exp(0, 3'd4, 1'b1, 8'h77);
    req[1] = 1'b1; req[0] = 1'b1;
    wait_resp();
    req[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt != '0) cnt++;
    end
    check_eq("locked_no_gnt", 32'(cnt), 32'd0);
    req = '0;
`else
    do_txn(1, 3'd3, 1'b1, 8'h14);
    check_eq("viol_five", 32'(viol_cnt), 32'd5);
    // Saturation of the violation counter.
    for (int i = 0; i < 255; i++) do_txn(i % NREQ, 3'd0, 1'b1, 8'(i));
    check_eq("viol_sat", 32'(viol_cnt), 32'd255);
`endif
    repeat (3) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
